sequenciador_ram64: RTL

- Initiator-side burst sequencer for the 64 x 16-bit RAM (minha_ram64).
- Accepts one burst request (read or write, start address, length) and drives the RAM's address, data and write-enable port word by word, with address wrap.
- Streams write data in and read data out through valid/ready handshakes.
- Sits between the program-counter/control logic and the RAM.

---
 rtl/sequenciador_ram64_pkg.sv | 16 +
 rtl/sequenciador_ram64_contador_endereco.sv | 38 +++
 rtl/sequenciador_ram64.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sequenciador_ram64_pkg.sv
// Shared widths and FSM state encoding for the 64 x 16-bit RAM burst sequencer.
package pacote_ram64;

  localparam int LARGURA_DADOS = 16;
  localparam int LARGURA_END   = 6;
  localparam int PROFUNDIDADE  = 64;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ESCRITA = 3'd1,
    LEITURA = 3'd2,
    DRENO   = 3'd3,
    FIM     = 3'd4
  } estado_t;

endpackage

// File: rtl/sequenciador_ram64_contador_endereco.sv
// Burst address register (load / increment with natural wrap) plus remaining-word down-counter.
module contador_endereco #(
  parameter int LARGURA_END = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_carregar,
  input  logic                   i_avancar,
  input  logic [LARGURA_END-1:0] i_endereco,
  input  logic [LARGURA_END:0]   i_comprimento,
  output logic [LARGURA_END-1:0] o_endereco,
  output logic [LARGURA_END:0]   o_restante
);

  logic [LARGURA_END-1:0] r_endereco;
  logic [LARGURA_END:0]   r_restante;
  logic [LARGURA_END:0]   w_comp_sat;

  // Any length with the top bit set means "more than the depth": clamp to a full sweep.
  assign w_comp_sat = i_comprimento[LARGURA_END] ? {1'b1, {LARGURA_END{1'b0}}} : i_comprimento;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_endereco <= '0;
      r_restante <= '0;
    end else if (i_carregar) begin
      r_endereco <= i_endereco;
      r_restante <= w_comp_sat;
    end else if (i_avancar) begin
      r_endereco <= r_endereco + 1'b1;
      r_restante <= r_restante - 1'b1;
    end
  end

  assign o_endereco = r_endereco;
  assign o_restante = r_restante;

endmodule

// File: rtl/sequenciador_ram64.sv
// Initiator-side burst sequencer for minha_ram64: one read/write burst per request, with wrap.
// Handshakes: a word moves on a rising edge where both valid and ready are high; valid never depends on ready.
module sequenciador_ram64 #(
  parameter int LARGURA_DADOS = pacote_ram64::LARGURA_DADOS,
  parameter int LARGURA_END   = pacote_ram64::LARGURA_END
) (
  input  logic                     clock_principal,
  input  logic                     reset_principal_n,
  input  logic                     req_valido,
  output logic                     req_pronto,
  input  logic                     req_escrita,
  input  logic [LARGURA_END-1:0]   req_endereco,
  input  logic [LARGURA_END:0]     req_comprimento,
  input  logic                     wdados_valido,
  input  logic [LARGURA_DADOS-1:0] wdados,
  output logic                     wdados_pronto,
  output logic                     rdados_valido,
  output logic [LARGURA_DADOS-1:0] rdados,
  input  logic                     rdados_pronto,
  output logic [LARGURA_END-1:0]   ram_endereco,
  output logic [LARGURA_DADOS-1:0] ram_dados_entrada,
  output logic                     ram_write,
  input  logic [LARGURA_DADOS-1:0] ram_dados_saida,
  output logic                     ocupado,
  output logic                     concluido,
  output pacote_ram64::estado_t    o_estado_dbg
);

  import pacote_ram64::*;

  localparam logic [LARGURA_END:0] ULTIMA = {{LARGURA_END{1'b0}}, 1'b1};

  estado_t                  r_estado;
  logic [LARGURA_DADOS-1:0] r_rdados;
  logic                     r_rdados_valido;
  logic                     r_concluido;

  logic [LARGURA_END-1:0]   w_endereco;
  logic [LARGURA_END:0]     w_restante;
  logic                     w_carregar;
  logic                     w_escreve;
  logic                     w_captura;
  logic                     w_avancar;

  assign w_carregar = (r_estado == OCIOSO) && req_valido;
  assign w_escreve  = (r_estado == ESCRITA) && wdados_valido;
  // The output buffer refills whenever it is empty or being drained this cycle.
  assign w_captura  = (r_estado == LEITURA) && (!r_rdados_valido || rdados_pronto);
  assign w_avancar  = w_escreve || w_captura;

  contador_endereco #(
    .LARGURA_END (LARGURA_END)
  ) u_contador (
    .i_clk         (clock_principal),
    .i_rst_n       (reset_principal_n),
    .i_carregar    (w_carregar),
    .i_avancar     (w_avancar),
    .i_endereco    (req_endereco),
    .i_comprimento (req_comprimento),
    .o_endereco    (w_endereco),
    .o_restante    (w_restante)
  );

  always_ff @(posedge clock_principal or negedge reset_principal_n) begin
    if (!reset_principal_n) begin
      r_estado        <= OCIOSO;
      r_rdados        <= '0;
      r_rdados_valido <= 1'b0;
      r_concluido     <= 1'b0;
    end else begin
      r_concluido <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (req_valido) begin
            if (req_comprimento == '0) begin
              r_estado    <= FIM;
              r_concluido <= 1'b1;
            end else begin
              r_estado <= req_escrita ? ESCRITA : LEITURA;
            end
          end
        end
        ESCRITA: begin
          if (wdados_valido && (w_restante == ULTIMA)) begin
            r_estado    <= FIM;
            r_concluido <= 1'b1;
          end
        end
        LEITURA: begin
          if (w_captura) begin
            r_rdados        <= ram_dados_saida;
            r_rdados_valido <= 1'b1;
            if (w_restante == ULTIMA) r_estado <= DRENO;
          end else if (rdados_pronto) begin
            r_rdados_valido <= 1'b0;
          end
        end
        DRENO: begin
          if (r_rdados_valido && rdados_pronto) begin
            r_rdados_valido <= 1'b0;
            r_estado        <= FIM;
            r_concluido     <= 1'b1;
          end
        end
        FIM:     r_estado <= OCIOSO;
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign req_pronto        = (r_estado == OCIOSO);
  assign ocupado           = (r_estado != OCIOSO);
  assign wdados_pronto     = (r_estado == ESCRITA);
  assign ram_write         = w_escreve;
  assign ram_endereco      = w_endereco;
  assign ram_dados_entrada = wdados;
  assign rdados            = r_rdados;
  assign rdados_valido     = r_rdados_valido;
  assign concluido         = r_concluido;
  assign o_estado_dbg      = r_estado;

endmodule
